idct_mac_round_sat: RTL



---
 rtl/idct_pkg.sv | 32 +++
 rtl/idct_mac_round_sat_if.sv | 30 +++
 rtl/idct_round_sat.sv | 38 +++
 rtl/idct_mac_round_sat.sv | 132 +++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT multiply-accumulate output stage:
// pass-state encodings, block geometry and default datapath widths.
package idct_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_LO   = 3'b010,
        ST_HI0  = 3'b011,
        ST_HI1  = 3'b100
    } pass_state_e;

    localparam int COEF_PER_BLK     = 64;
    localparam int IDX_W            = $clog2(COEF_PER_BLK);
    localparam int PROD_W           = 32;

    localparam int DEF_N_TAPS       = 8;
    localparam int DEF_ACC_W        = 36;
    localparam int DEF_ROUND_SHIFT  = 12;
    localparam int DEF_OUT_W        = 16;

    // True for the pass states in which products carry real IDCT data.
    function automatic logic is_pass_state(input logic [2:0] s);
        logic ok;
        case (s)
            ST_LO, ST_HI0, ST_HI1: ok = 1'b1;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/idct_mac_round_sat_if.sv
// Product-in / coefficient-out handshake bundle of the MAC stage.
// master = product source plus coefficient sink, slave = MAC stage.
interface idct_mac_round_sat_if
    import idct_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) ();

    logic signed [PROD_W-1:0] P;
    logic [2:0]               state_in;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         coef_idx;
    logic                     blk_done;
    logic                     pass_err;

    modport master (
        output P, state_in, prod_valid, out_ready,
        input  prod_ready, out_data, out_valid, coef_idx, blk_done, pass_err
    );

    modport slave (
        input  P, state_in, prod_valid, out_ready,
        output prod_ready, out_data, out_valid, coef_idx, blk_done, pass_err
    );

endinterface

// File: rtl/idct_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed clamp of a
// wide accumulator value to an OUT_W-bit coefficient. Shared with the
// row/column transpose stage.
module idct_round_sat #(
    parameter int ACC_W       = 36,
    parameter int ROUND_SHIFT = 12,
    parameter int OUT_W       = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] coef
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] HALF_C =
        {{(EXT_W-1){1'b0}}, 1'b1} << (ROUND_SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAX_C =
        {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_C = ~MAX_C;

    logic signed [EXT_W-1:0] biased_s;
    logic signed [EXT_W-1:0] shifted_s;

    // Bias by half an output LSB, floor-shift, then clamp into range
    always_comb begin
        biased_s  = $signed({acc[ACC_W-1], acc}) + HALF_C;
        shifted_s = biased_s >>> ROUND_SHIFT;
        if (shifted_s > MAX_C) begin
            coef = MAX_C[OUT_W-1:0];
        end else if (shifted_s < MIN_C) begin
            coef = MIN_C[OUT_W-1:0];
        end else begin
            coef = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/idct_mac_round_sat.sv
// IDCT dot-product stage: sums N_TAPS products from the approximate
// multiplier wrapper, rounds/shifts/saturates the sum into one coefficient,
// and hands it downstream with its position inside the 8x8 block.
module idct_mac_round_sat
    import idct_pkg::*;
#(
    parameter int N_TAPS      = DEF_N_TAPS,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int ROUND_SHIFT = DEF_ROUND_SHIFT,
    parameter int OUT_W       = DEF_OUT_W
) (
    input  logic                 clk,
    input  logic                 rstP,
    idct_mac_round_sat_if.slave  bus
);

    localparam int TAP_W = $clog2(N_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COEF_PER_BLK - 1);

    logic signed [ACC_W-1:0] acc_r;
    logic [TAP_W-1:0]        tap_cnt_r;
    logic [2:0]              first_state_r;
    logic signed [OUT_W-1:0] out_data_r;
    logic                    out_valid_r;
    logic [IDX_W-1:0]        coef_idx_r;
    logic                    blk_done_r;
    logic                    pass_err_r;

    logic                    prod_ready_s;
    logic                    idle_s;
    logic                    accept_s;
    logic                    last_tap_s;
    logic                    retire_s;
    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [OUT_W-1:0] coef_s;

    // Handshake qualification and the running sum including this product
    always_comb begin
        prod_ready_s = ~out_valid_r | bus.out_ready;
        idle_s       = (bus.state_in == ST_IDLE);
        accept_s     = bus.prod_valid & prod_ready_s & is_pass_state(bus.state_in);
        last_tap_s   = accept_s & (tap_cnt_r == LAST_TAP);
        retire_s     = out_valid_r & bus.out_ready;
        p_ext_s      = {{(ACC_W-PROD_W){bus.P[PROD_W-1]}}, bus.P};
        sum_s        = acc_r + p_ext_s;
    end

    idct_round_sat #(
        .ACC_W       (ACC_W),
        .ROUND_SHIFT (ROUND_SHIFT),
        .OUT_W       (OUT_W)
    ) u_round_sat (
        .acc  (sum_s),
        .coef (coef_s)
    );

    // Partial-sum accumulation; idle state aborts any sum in progress
    always_ff @(posedge clk) begin
        if (rstP) begin
            acc_r     <= '0;
            tap_cnt_r <= '0;
        end else if (idle_s) begin
            acc_r     <= '0;
            tap_cnt_r <= '0;
        end else if (last_tap_s) begin
            acc_r     <= '0;
            tap_cnt_r <= '0;
        end else if (accept_s) begin
            acc_r     <= sum_s;
            tap_cnt_r <= tap_cnt_r + TAP_W'(1);
        end else begin
            acc_r     <= acc_r;
            tap_cnt_r <= tap_cnt_r;
        end
    end

    // Output register, coefficient position and end-of-block pulse
    always_ff @(posedge clk) begin
        if (rstP) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            coef_idx_r  <= '0;
            blk_done_r  <= 1'b0;
        end else begin
            blk_done_r <= retire_s & (coef_idx_r == LAST_IDX);
            if (retire_s) begin
                coef_idx_r <= coef_idx_r + IDX_W'(1);
            end else begin
                coef_idx_r <= coef_idx_r;
            end
            if (last_tap_s) begin
                out_data_r  <= coef_s;
                out_valid_r <= 1'b1;
            end else if (retire_s) begin
                out_data_r  <= out_data_r;
                out_valid_r <= 1'b0;
            end else begin
                out_data_r  <= out_data_r;
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Remember the pass state of the first tap; flag a change mid-sum
    always_ff @(posedge clk) begin
        if (rstP) begin
            first_state_r <= ST_IDLE;
            pass_err_r    <= 1'b0;
        end else if (accept_s) begin
            if (tap_cnt_r == '0) begin
                first_state_r <= bus.state_in;
                pass_err_r    <= pass_err_r;
            end else begin
                first_state_r <= first_state_r;
                pass_err_r    <= pass_err_r | (bus.state_in != first_state_r);
            end
        end else begin
            first_state_r <= first_state_r;
            pass_err_r    <= pass_err_r;
        end
    end

    assign bus.prod_ready = prod_ready_s;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.coef_idx   = coef_idx_r;
    assign bus.blk_done   = blk_done_r;
    assign bus.pass_err   = pass_err_r;

endmodule
